// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory: IDLE -> ISSUE -> RESP.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 always wins ties.

module dmem_arb_port #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  capture,
  input  logic                  resp,
  input  logic                  rd_ok,
  input  logic                  err_in,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata
);
  // rdata holds until this port's next completion; writes and errors zero it.
  always_ff @(posedge clk) begin
    if (rst)                 rdata <= '0;
    else if (capture && sel) rdata <= rd_ok ? mem_rd_data : '0;
  end

  assign ack = resp & sel;
  assign err = resp & sel & err_in;
endmodule

module dmem_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h0200_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_TOP    = 32'h0200_1FFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  grant_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                      state, state_nxt;
  logic   [1:0]                req;
  req_t   [1:0]                req_in;
  req_t                        req_sel, cur;
  logic                        cur_err, sel_err, win, gnt;
  logic                        issue_cyc, resp_cyc;
  logic   [1:0]                ack_v, err_v;
  logic   [1:0][DATA_WIDTH-1:0] rdata_v;

  assign req       = {m1_req, m0_req};
  assign req_in[0] = {m0_we, m0_addr, m0_wdata};
  assign req_in[1] = {m1_we, m1_addr, m1_wdata};

`ifdef DMEM_ARB_RR_EN
  logic rr_last;
  // Ties go to the port that did not win last; a lone requester always wins.
  always_comb win = (&req) ? ~rr_last : req[1];
`else
  always_comb win = ~req[0];
`endif

  assign req_sel = req_in[win];
  assign sel_err = (req_sel.addr < MEM_BASE) | (req_sel.addr > MEM_TOP) | (|req_sel.addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      cur_err <= 1'b0;
      gnt     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_last <= 1'b1;
`endif
    end else if (state == IDLE && |req) begin
      cur     <= req_sel;
      cur_err <= sel_err;
      gnt     <= win;
`ifdef DMEM_ARB_RR_EN
      rr_last <= win;
`endif
    end
  end

  // Memory bus is driven only in ISSUE; rst kills a write landing on that cycle.
  always_comb begin
    busy        = (state != IDLE);
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    issue_cyc   = (state == ISSUE) & ~rst;
    resp_cyc    = (state == RESP)  & ~rst;
    if (state == ISSUE) begin
      mem_addr    = cur.addr;
      mem_wr_data = cur.wdata;
      mem_wr_en   = cur.we & ~cur_err & ~rst;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    dmem_arb_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
      .clk         (clk),
      .rst         (rst),
      .sel         (gnt == 1'(i)),
      .capture     (issue_cyc),
      .resp        (resp_cyc),
      .rd_ok       (~cur.we & ~cur_err),
      .err_in      (cur_err),
      .mem_rd_data (mem_rd_data),
      .ack         (ack_v[i]),
      .err         (err_v[i]),
      .rdata       (rdata_v[i])
    );
  end

  assign grant_id = gnt;
  assign m0_ack   = ack_v[0];
  assign m1_ack   = ack_v[1];
  assign m0_err   = err_v[0];
  assign m1_err   = err_v[1];
  assign m0_rdata = rdata_v[0];
  assign m1_rdata = rdata_v[1];
endmodule
